// File: rtl/systolic_pkg.sv
// Shared types for the 2x2 systolic multiplier result path.
//   PROD_W          - width of one product
//   PRODS_PER_FRAME - products produced by one multiply (p0..p3)
//   prod_t          - one product
//   frame_t         - the four products of one multiply; element k holds pk
//   drain_state_t   - states of the result drain FSM
package systolic_pkg;
  localparam int PROD_W          = 16;
  localparam int PRODS_PER_FRAME = 4;

  typedef logic [PROD_W-1:0] prod_t;
  typedef prod_t [PRODS_PER_FRAME-1:0] frame_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;
endpackage

// File: rtl/frame_fifo.sv
// Circular buffer of DEPTH complete product frames.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears storage too)
//   push_i    - write din_i at the tail (caller guarantees !full_o)
//   din_i     - frame to write
//   pop_i     - drop the head frame (caller guarantees !empty_o)
//   head_o    - frame at the head, read straight from storage
//   count_o   - number of stored frames, 0..DEPTH
//   full_o    - count_o == DEPTH
//   empty_o   - count_o == 0
module frame_fifo
  import systolic_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  frame_t           din_i,
  input  logic             pop_i,
  output frame_t           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  frame_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Push and pop in the same cycle leave the occupancy unchanged.
  always_comb begin
    count_d = count_q + {{(CNT_W-1){1'b0}}, push_i} - {{(CNT_W-1){1'b0}}, pop_i};
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/systolic1x4_result_drain.sv
// Reader end of the 2x2 systolic multiplier result interface.
// Accepts one frame {p0,p1,p2,p3} per in_valid/in_ready handshake, buffers
// up to DEPTH frames and replays each as four DW-bit beats p0,p1,p2,p3 on a
// valid/ready stream.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid / in_ready   - frame handshake; in_ready depends only on the
//                           registered occupancy, never on out_ready
//   p0..p3                - products x0*y0, x1*y0, x0*y1, x1*y1
//   out_valid / out_ready - beat handshake
//   out_data              - current beat (0 while out_valid is low)
//   out_idx, out_last     - beat index within its frame, high on index 3
//   frames_sent           - fully drained frames, wraps modulo 2^CW
module systolic1x4_result_drain
  import systolic_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] p0,
  input  logic [DW-1:0] p1,
  input  logic [DW-1:0] p2,
  input  logic [DW-1:0] p3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_idx,
  output logic          out_last,
  output logic [CW-1:0] frames_sent
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  drain_state_t     state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CW-1:0]    sent_q, sent_d;

  frame_t           in_frame;
  frame_t           head;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             beat_xfer;

  assign in_frame[0] = p0;
  assign in_frame[1] = p1;
  assign in_frame[2] = p2;
  assign in_frame[3] = p3;

  // A full buffer refuses the push even if the head drains on this edge.
  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign beat_xfer = out_valid && out_ready;
  assign pop       = beat_xfer && (idx_q == 2'd3) && !fifo_empty;

  frame_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (in_frame),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register plus beat counter and drained-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
    end
  end

  // Next state: leave STREAM only when the last stored frame finishes and
  // nothing new arrives on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (push) state_d = STREAM;
      STREAM:  if (pop && !push && (count == CNT_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The 2-bit beat index rolls 3 -> 0 on its own, which starts the next
  // frame at beat 0 with no bubble.
  always_comb begin
    idx_d  = beat_xfer ? idx_q + 2'd1 : idx_q;
    sent_d = pop ? sent_q + 1'b1 : sent_q;
  end

  // Outputs come from state and stored frames only, never from p0..p3.
  always_comb begin
    out_valid   = (state_q == STREAM);
    out_idx     = idx_q;
    out_last    = out_valid && (idx_q == 2'd3);
    out_data    = out_valid ? head[idx_q] : '0;
    frames_sent = sent_q;
  end
endmodule

// File: tb/tb_systolic1x4_result_drain.sv
module tb_systolic1x4_result_drain;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] p0, p1, p2, p3;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_idx;
  logic          out_last;
  logic [CW-1:0] frames_sent;

  int checks;
  int failures;
  int exp_sent;

  systolic1x4_result_drain #(
    .DW    (DW),
    .DEPTH (2),
    .CW    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .p0          (p0),
    .p1          (p1),
    .p2          (p2),
    .p3          (p3),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_frame(input int a, input int b, input int c, input int d);
    p0 = DW'(a); p1 = DW'(b); p2 = DW'(c); p3 = DW'(d);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_frame(0, 0, 0, 0);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_data !== 16'd0) begin failures++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (frames_sent !== 4'd0) begin failures++; $display("FAIL reset_frames_sent got=%0d want=0", frames_sent); end
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b want=0", out_valid); end
    exp_sent = 0;
  endtask

  task automatic test_single();
    int exp_d [4] = '{32, 8, 24, 6};
    out_ready = 1'b1;
    in_valid = 1'b1; set_frame(32, 8, 24, 6);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'(exp_d[b]) || out_idx !== 2'(b) || out_last !== (b == 3))
        begin failures++; $display("FAIL single_beat%0d got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b", b, out_valid, out_data, out_idx, out_last, exp_d[b], b, (b == 3)); end
      tick();
    end
    exp_sent++;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_idle got=%b want=0", out_valid); end
    checks++; if (frames_sent !== 4'(exp_sent)) begin failures++; $display("FAIL single_sent got=%0d want=%0d", frames_sent, exp_sent); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    in_valid = 1'b1; set_frame(20, 10, 60, 30);
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 16'd20 || out_idx !== 2'd0) begin failures++; $display("FAIL bp_beat0 got d=%0d i=%0d want d=20 i=0", out_data, out_idx); end
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'd10 || out_idx !== 2'd1 || out_last !== 1'b0)
        begin failures++; $display("FAIL bp_stall%0d got v=%b d=%0d i=%0d want v=1 d=10 i=1", s, out_valid, out_data, out_idx); end
      tick();
    end
    out_ready = 1'b1;
    checks++; if (out_data !== 16'd10 || out_idx !== 2'd1) begin failures++; $display("FAIL bp_release got d=%0d i=%0d want d=10 i=1", out_data, out_idx); end
    tick();
    checks++; if (out_data !== 16'd60 || out_idx !== 2'd2) begin failures++; $display("FAIL bp_beat2 got d=%0d i=%0d want d=60 i=2", out_data, out_idx); end
    tick();
    checks++; if (out_data !== 16'd30 || out_last !== 1'b1) begin failures++; $display("FAIL bp_beat3 got d=%0d l=%b want d=30 l=1", out_data, out_last); end
    tick();
    exp_sent++;
    checks++; if (out_valid !== 1'b0 || frames_sent !== 4'(exp_sent)) begin failures++; $display("FAIL bp_done got v=%b sent=%0d want v=0 sent=%0d", out_valid, frames_sent, exp_sent); end
  endtask

  task automatic test_fill();
    int exp_d [8] = '{20, 10, 60, 30, 255, 255, 255, 255};
    out_ready = 1'b0;
    in_valid = 1'b1; set_frame(20, 10, 60, 30);
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_after1 got=%b want=1", in_ready); end
    set_frame(255, 255, 255, 255);
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_after2 got=%b want=0", in_ready); end
    set_frame(7, 7, 7, 7);
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_refused got=%b want=0", in_ready); end
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'(exp_d[b]) || out_idx !== 2'(b % 4))
        begin failures++; $display("FAIL fill_beat%0d got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d", b, out_valid, out_data, out_idx, exp_d[b], b % 4); end
      tick();
    end
    exp_sent += 2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_third_dropped got v=%b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_end got=%b want=1", in_ready); end
    checks++; if (frames_sent !== 4'(exp_sent)) begin failures++; $display("FAIL fill_sent got=%0d want=%0d", frames_sent, exp_sent); end
  endtask

  // Frames are pushed on the cycle their predecessor shows beat 3, so a
  // push and a pop share that edge.
  task automatic test_back_to_back(input int nframes, input int base, input string tag);
    int expv;
    out_ready = 1'b1;
    in_valid = 1'b1; set_frame(base, base + 1, base + 2, base + 3);
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < nframes * 4; b++) begin
      expv = base + (b / 4) * 4 + (b % 4);
      checks++; if (out_valid !== 1'b1 || out_data !== 16'(expv) || out_idx !== 2'(b % 4) || out_last !== ((b % 4) == 3))
        begin failures++; $display("FAIL %s_beat%0d got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d", tag, b, out_valid, out_data, out_idx, out_last, expv, b % 4); end
      if ((b % 4) == 3 && (b / 4) < nframes - 1) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_ready%0d got=%b want=1", tag, b, in_ready); end
        in_valid = 1'b1;
        set_frame(base + (b / 4 + 1) * 4, base + (b / 4 + 1) * 4 + 1, base + (b / 4 + 1) * 4 + 2, base + (b / 4 + 1) * 4 + 3);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    exp_sent += nframes;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_idle got=%b want=0", tag, out_valid); end
    checks++; if (frames_sent !== 4'(exp_sent % 16)) begin failures++; $display("FAIL %s_sent got=%0d want=%0d", tag, frames_sent, exp_sent % 16); end
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b1;
    in_valid = 1'b1; set_frame(5, 6, 7, 8);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (out_idx !== 2'd2 || out_data !== 16'd7) begin failures++; $display("FAIL rst_mid_pre got i=%0d d=%0d want i=2 d=7", out_idx, out_data); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || frames_sent !== 4'd0)
      begin failures++; $display("FAIL rst_mid_async got v=%b r=%b sent=%0d want v=0 r=1 sent=0", out_valid, in_ready, frames_sent); end
    @(negedge clk);
    rst = 1'b0;
    exp_sent = 0;
    tick();
    in_valid = 1'b1; set_frame(1, 2, 3, 4);
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'(b + 1) || out_idx !== 2'(b))
        begin failures++; $display("FAIL rst_mid_beat%0d got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d", b, out_valid, out_data, out_idx, b + 1, b); end
      tick();
    end
    exp_sent++;
    checks++; if (frames_sent !== 4'(exp_sent)) begin failures++; $display("FAIL rst_mid_sent got=%0d want=%0d", frames_sent, exp_sent); end
  endtask

  initial begin
    checks = 0; failures = 0; exp_sent = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_back_to_back(3, 100, "b2b");
    test_reset_mid_stream();
    // 1 frame already sent; 16 more wrap the 4-bit counter back to 1.
    test_back_to_back(16, 1000, "wrap");
    checks++; if (frames_sent !== 4'd1) begin failures++; $display("FAIL wrap_final got=%0d want=1", frames_sent); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic1x4_result_drain.md
Name: systolic1x4_result_drain

Overview:
- Output-side companion to the 2x2 systolic matrix multiplier. It captures the four 16-bit products p0..p3 of one multiply as a single "frame", under a valid/ready handshake.
- It buffers up to DEPTH frames and replays each frame as a serial stream of 16-bit beats for a narrow downstream consumer.
- It is the reader end of the multiplier's result interface.

Parameters:
- DW, 16, width of one product and of out_data.
- DEPTH, 2, number of 4-product frames buffered; power of two, at least 2.
- CW, 16, width of the frames_sent counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  p0..p3 hold a valid frame.
- in_ready  output  1  the block can accept a frame this cycle.
- p0  input  DW  product x0*y0.
- p1  input  DW  product x1*y0.
- p2  input  DW  product x0*y1.
- p3  input  DW  product x1*y1.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  the consumer accepts the beat.
- out_data  output  DW  current product beat.
- out_idx  output  2  index (0..3) of the current beat within its frame.
- out_last  output  1  high on beat index 3.
- frames_sent  output  CW  count of fully drained frames; wraps modulo 2^CW.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, in_ready=1, out_data=0, out_idx=0, out_last=0, frames_sent=0.
  - All frame storage, pointers, counters and FSM are cleared.
  - Asserting rst mid-stream discards every buffered frame and any partially sent frame immediately.
- Frame buffer:
  - Circular buffer of DEPTH entries, each holding {p0,p1,p2,p3}.
  - Write pointer, read pointer and a count register of width log2(DEPTH)+1.
- Push:
  - Occurs when in_valid && in_ready at a rising edge.
  - in_ready = (count != DEPTH). It is derived from registered count only and never depends on out_ready.
  - When full, a push is refused even if the head frame completes in the same cycle.
- FSM states:
  - IDLE: count==0, out_valid=0. Goes to STREAM on the edge that pushes a frame.
  - STREAM: out_valid=1, out_idx=beat counter, out_data=head frame element[out_idx] (order p0, p1, p2, p3), out_last=(out_idx==3).
- Beat transfer:
  - A beat transfers on out_valid && out_ready.
  - After a transfer on idx<3, idx increments.
  - After a transfer on idx==3: idx returns to 0, the head frame is popped, and frames_sent increments by 1.
  - The FSM stays in STREAM if count after the update is nonzero; otherwise it returns to IDLE.
- Latency: a frame pushed at edge N into an empty buffer presents beat 0 in the cycle after edge N. out_data is registered from the buffer, with no combinational path from p0..p3.
- Stability: while out_valid && !out_ready, out_data, out_idx and out_last hold constant.
- Simultaneous push and pop (count<DEPTH): count is unchanged, both pointers advance, and streaming continues with beat 0 of the next frame in the following cycle. There are no bubbles between back-to-back frames.
- Pointers wrap modulo DEPTH.
- frames_sent wraps from 2^CW-1 to 0.
- Products pass through unmodified. There is no arithmetic on data; widths are exact DW.

Decomposition:
- Shared package systolic_pkg holds:
  - constants PROD_W=16 and PRODS_PER_FRAME=4;
  - typedef prod_t (logic [PROD_W-1:0]);
  - typedef frame_t (array of 4 prod_t);
  - enum drain_state_t {IDLE, STREAM}.
- One sub-module is natural: frame_fifo (DEPTH-entry frame_t FIFO with push, pop, count, full and empty). The FSM, beat counter and frames_sent live in the top module.

Test Plan:
- Reset, then one frame p0..p3 = 32,8,24,6 with out_ready=1:
  - beats 32,8,24,6 appear on consecutive cycles starting the cycle after the push;
  - out_idx runs 0..3; out_last is high only on 6;
  - frames_sent=1; the block then returns to IDLE with out_valid=0.
- Backpressure: frame 20,10,60,30 with out_ready low for 3 cycles during beat 1:
  - out_data holds 10 and out_idx holds 1 throughout the stall;
  - beats resume 60,30 once out_ready rises.
- Fill: out_ready=0, push frames {20,10,60,30}, {255,255,255,255} and a third frame:
  - in_ready drops after the second push, so the third frame is not accepted;
  - after draining 8 beats, in_ready=1 and frames_sent=2.
- Back-to-back: continuous pushes with out_ready=1:
  - 3 frames produce 12 gap-free beats;
  - a push and a pop coincide on each idx==3 transfer, and count stays unchanged.
- Reset mid-stream: assert rst during beat 2 of a frame:
  - out_valid=0, in_ready=1 and frames_sent=0 immediately;
  - a new frame 1,2,3,4 after release streams from beat 0.
- Wrap: run 2^CW+1 frames, or a bench build with CW=4 and 17 frames:
  - frames_sent reads 1 at the end;
  - the buffer pointers wrap with data order preserved.
